gcnt_param: RTL and testbench

//  Parametrised Gray-code counter. It generalises the fixed 4-bit gcnt to WIDTH bits.

---
 rtl/gcnt_param.sv | 80 ++++++++
 tb/tb_gcnt_param.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcnt_param.sv
// Parametrised Gray-code counter with up/down, Gray load, clear, wrap/saturate
// modes, a registered binary shadow and a registered terminal-count flag.
module gcnt_param #(
  parameter int WIDTH     = 4,
  parameter bit SATURATE  = 1'b0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] bin_reg, bin_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic             tc_reg, tc_next;
  logic [WIDTH-1:0] load_bin;
  logic             at_max, at_min;

  // Each binary bit is the XOR-reduction of the Gray bits at and above it.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_g2b
      assign load_bin[gi] = ^load_gray[WIDTH-1:gi];
    end
  endgenerate

  assign at_max = &bin_reg;
  assign at_min = ~|bin_reg;

  always_comb begin
    bin_next  = bin_reg;
    gray_next = gray_reg;
    tc_next   = 1'b0;
    if (clr) begin
      bin_next  = '0;
      gray_next = '0;
    end else if (load) begin
      bin_next  = load_bin;
      gray_next = load_gray;
    end else if (trig) begin
      if ((dir && at_max) || (!dir && at_min)) begin
        // End of range: saturate blocks the step, wrap mode flags the rollover.
        tc_next = 1'b1;
        if (!SATURATE) begin
          bin_next = dir ? '0 : '1;
        end
      end else begin
        bin_next = dir ? bin_reg + 1'b1 : bin_reg - 1'b1;
      end
      gray_next = bin_next ^ (bin_next >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_reg  <= RST_BIN;
      gray_reg <= RST_GRAY;
      tc_reg   <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      tc_reg   <= tc_next;
    end
  end

  assign count_out = gray_reg;
  assign bin_out   = bin_reg;
  assign tc        = tc_reg;

endmodule

// File: tb/tb_gcnt_param.sv
// Directed and randomised checks of gcnt_param across wrap, saturate,
// non-zero reset value and 8-bit configurations.
module tb_gcnt_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic trig = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_gray = 4'd0;
  logic [7:0] load_gray8 = 8'd0;

  logic [3:0] w_cnt, w_bin, s_cnt, s_bin, r_cnt, r_bin;
  logic [7:0] e_cnt, e_bin;
  logic       w_tc, s_tc, r_tc, e_tc;

  int checks = 0;
  int errors = 0;

  logic [3:0] gtab [0:15] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                              4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  always #5 clk = ~clk;

  gcnt_param #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(0)) u_wrap (
    .clk(clk), .rst(rst), .trig(trig), .dir(dir), .clr(clr), .load(load),
    .load_gray(load_gray), .count_out(w_cnt), .bin_out(w_bin), .tc(w_tc));

  gcnt_param #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(0)) u_sat (
    .clk(clk), .rst(rst), .trig(trig), .dir(dir), .clr(clr), .load(load),
    .load_gray(load_gray), .count_out(s_cnt), .bin_out(s_bin), .tc(s_tc));

  gcnt_param #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(5)) u_rv5 (
    .clk(clk), .rst(rst), .trig(trig), .dir(dir), .clr(clr), .load(load),
    .load_gray(load_gray), .count_out(r_cnt), .bin_out(r_bin), .tc(r_tc));

  gcnt_param #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(0)) u_w8 (
    .clk(clk), .rst(rst), .trig(trig), .dir(dir), .clr(clr), .load(load),
    .load_gray(load_gray8), .count_out(e_cnt), .bin_out(e_bin), .tc(e_tc));

  function automatic logic [7:0] g2b8(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    trig = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0; load_gray = 4'd0;
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (w_cnt !== 4'd0 || w_bin !== 4'd0 || w_tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrap: got cnt=%b bin=%0d tc=%b, want 0000/0/0", w_cnt, w_bin, w_tc);
    end
    checks++;
    if (r_cnt !== 4'b0111 || r_bin !== 4'd5 || r_tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_rv5: got cnt=%b bin=%0d tc=%b, want 0111/5/0", r_cnt, r_bin, r_tc);
    end
    $display("reset: wrap cnt=%b bin=%0d rv5 cnt=%b bin=%0d", w_cnt, w_bin, r_cnt, r_bin);
  endtask

  task automatic test_count_up();
    do_reset();
    trig = 1'b1; dir = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (w_cnt !== gtab[i%16] || w_bin !== 4'(i%16) || w_tc !== (i == 16)) begin
        errors++;
        $display("FAIL count_up[%0d]: got cnt=%b bin=%0d tc=%b, want %b/%0d/%b",
                 i, w_cnt, w_bin, w_tc, gtab[i%16], i%16, (i == 16));
      end
      $display("up step %0d: cnt=%b bin=%0d tc=%b", i, w_cnt, w_bin, w_tc);
    end
    trig = 1'b0;
    step();
    checks++;
    if (w_cnt !== 4'd0 || w_tc !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_wrap: got cnt=%b tc=%b, want 0000/0", w_cnt, w_tc);
    end
  endtask

  task automatic test_count_down();
    do_reset();
    trig = 1'b1; dir = 1'b0;
    step();
    checks++;
    if (w_cnt !== 4'b1000 || w_bin !== 4'd15 || w_tc !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: got cnt=%b bin=%0d tc=%b, want 1000/15/1", w_cnt, w_bin, w_tc);
    end
    $display("down step 1: cnt=%b bin=%0d tc=%b", w_cnt, w_bin, w_tc);
    step();
    checks++;
    if (w_cnt !== 4'b1001 || w_bin !== 4'd14 || w_tc !== 1'b0) begin
      errors++;
      $display("FAIL down_step: got cnt=%b bin=%0d tc=%b, want 1001/14/0", w_cnt, w_bin, w_tc);
    end
    $display("down step 2: cnt=%b bin=%0d tc=%b", w_cnt, w_bin, w_tc);
    trig = 1'b0;
    step();
    checks++;
    if (w_cnt !== 4'b1001 || w_bin !== 4'd14 || w_tc !== 1'b0) begin
      errors++;
      $display("FAIL down_hold: got cnt=%b bin=%0d tc=%b, want 1001/14/0", w_cnt, w_bin, w_tc);
    end
  endtask

  task automatic test_load_clr();
    do_reset();
    load = 1'b1; load_gray = 4'b1111;
    step();
    checks++;
    if (w_cnt !== 4'b1111 || w_bin !== 4'd10 || w_tc !== 1'b0) begin
      errors++;
      $display("FAIL load: got cnt=%b bin=%0d tc=%b, want 1111/10/0", w_cnt, w_bin, w_tc);
    end
    $display("load 1111: cnt=%b bin=%0d", w_cnt, w_bin);
    clr = 1'b1; load_gray = 4'b0101;
    step();
    checks++;
    if (w_cnt !== 4'd0 || w_bin !== 4'd0) begin
      errors++;
      $display("FAIL clr_over_load: got cnt=%b bin=%0d, want 0000/0", w_cnt, w_bin);
    end
    $display("clr+load: cnt=%b bin=%0d", w_cnt, w_bin);
    clr = 1'b0; load_gray = 4'b0110; trig = 1'b1; dir = 1'b1;
    step();
    checks++;
    if (w_cnt !== 4'b0110 || w_bin !== 4'd4) begin
      errors++;
      $display("FAIL load_over_trig: got cnt=%b bin=%0d, want 0110/4", w_cnt, w_bin);
    end
    $display("load+trig: cnt=%b bin=%0d", w_cnt, w_bin);
    load = 1'b0;
    step();
    checks++;
    if (w_cnt !== 4'b0111 || w_bin !== 4'd5) begin
      errors++;
      $display("FAIL count_after_load: got cnt=%b bin=%0d, want 0111/5", w_cnt, w_bin);
    end
    trig = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    trig = 1'b1; dir = 1'b1;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (s_cnt !== 4'b1000 || s_bin !== 4'd15 || s_tc !== 1'b0) begin
      errors++;
      $display("FAIL sat_reach_max: got cnt=%b bin=%0d tc=%b, want 1000/15/0", s_cnt, s_bin, s_tc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s_cnt !== 4'b1000 || s_bin !== 4'd15 || s_tc !== 1'b1) begin
        errors++;
        $display("FAIL sat_hold[%0d]: got cnt=%b bin=%0d tc=%b, want 1000/15/1", i, s_cnt, s_bin, s_tc);
      end
      $display("sat blocked %0d: cnt=%b bin=%0d tc=%b", i, s_cnt, s_bin, s_tc);
    end
    dir = 1'b0;
    step();
    checks++;
    if (s_cnt !== 4'b1001 || s_bin !== 4'd14 || s_tc !== 1'b0) begin
      errors++;
      $display("FAIL sat_release: got cnt=%b bin=%0d tc=%b, want 1001/14/0", s_cnt, s_bin, s_tc);
    end
    trig = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; trig = 1'b1; dir = 1'b0;
    step();
    checks++;
    if (s_cnt !== 4'd0 || s_bin !== 4'd0 || s_tc !== 1'b1) begin
      errors++;
      $display("FAIL sat_min: got cnt=%b bin=%0d tc=%b, want 0000/0/1", s_cnt, s_bin, s_tc);
    end
    $display("sat at min: cnt=%b bin=%0d tc=%b", s_cnt, s_bin, s_tc);
    trig = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    trig = 1'b1; dir = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (r_cnt !== 4'b1100 || r_bin !== 4'd8) begin
      errors++;
      $display("FAIL rv5_count: got cnt=%b bin=%0d, want 1100/8", r_cnt, r_bin);
    end
    load = 1'b1; load_gray = 4'b1010;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (r_cnt !== 4'b0111 || r_bin !== 4'd5 || r_tc !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got cnt=%b bin=%0d tc=%b, want 0111/5/0", r_cnt, r_bin, r_tc);
    end
    $display("async reset: cnt=%b bin=%0d tc=%b", r_cnt, r_bin, r_tc);
    step();
    step();
    checks++;
    if (r_cnt !== 4'b0111 || r_bin !== 4'd5) begin
      errors++;
      $display("FAIL reset_held: got cnt=%b bin=%0d, want 0111/5", r_cnt, r_bin);
    end
    load = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (r_cnt !== 4'b0101 || r_bin !== 4'd6) begin
      errors++;
      $display("FAIL resume: got cnt=%b bin=%0d, want 0101/6", r_cnt, r_bin);
    end
    trig = 1'b0;
  endtask

  task automatic test_random8();
    logic [7:0] model, prev_cnt;
    logic       t, d, exp_tc;
    int         step_errs;
    do_reset();
    model = 8'd0;
    step_errs = errors;
    for (int i = 0; i < 1000; i++) begin
      t = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      trig = t; dir = d;
      prev_cnt = e_cnt;
      exp_tc = t && ((d && model == 8'hFF) || (!d && model == 8'h00));
      if (t) model = d ? model + 8'd1 : model - 8'd1;
      step();
      checks++;
      if (e_bin !== model || e_cnt !== (model ^ (model >> 1)) || e_tc !== exp_tc) begin
        errors++;
        $display("FAIL rand_value[%0d]: got cnt=%h bin=%h tc=%b, want %h/%h/%b",
                 i, e_cnt, e_bin, e_tc, model ^ (model >> 1), model, exp_tc);
      end
      checks++;
      if ($countones(prev_cnt ^ e_cnt) !== (t ? 1 : 0)) begin
        errors++;
        $display("FAIL rand_onebit[%0d]: got %0d bit changes, want %0d",
                 i, $countones(prev_cnt ^ e_cnt), t ? 1 : 0);
      end
      checks++;
      if (e_bin !== g2b8(e_cnt)) begin
        errors++;
        $display("FAIL rand_shadow[%0d]: got bin=%h, want %h", i, e_bin, g2b8(e_cnt));
      end
    end
    trig = 1'b0;
    $display("random8: 1000 cycles, final bin=%h, %0d new errors", e_bin, errors - step_errs);
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clr();
    test_saturate();
    test_async_reset();
    test_random8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
